// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch FIFO entry type for the fetch stage.
package fetch_pkg;

  localparam int unsigned ARCH_WIDTH  = 64;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ARCH_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Head is read straight from storage so the core sees it the cycle after a push.
  assign head = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush takes priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: sequential requests to program memory, in-order
// responses into a prefetch FIFO, redirect flushes buffered and in-flight work.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned           DEPTH    = 4,
  parameter logic [ARCH_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [ARCH_WIDTH-1:0]  redirect_pc,
  output logic                   mem_req_valid,
  output logic [ARCH_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data,
  output logic                   inst_valid,
  output logic [ARCH_WIDTH-1:0]  inst_pc,
  output logic [INSTR_WIDTH-1:0] inst_data,
  input  logic                   inst_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ARCH_WIDTH-1:0] fetch_pc, fetch_pc_d;
  logic [ARCH_WIDTH-1:0] resp_pc, resp_pc_d;
  logic [ARCH_WIDTH-1:0] redirect_tgt;
  logic [CNT_W-1:0]      outstanding, outstanding_d;
  logic [CNT_W-1:0]      drop, drop_d;
  logic [CNT_W-1:0]      count;
  logic                  credit_ok;
  logic                  req_fire, resp_fire, drop_resp, push, pop;
  fetch_entry_t          push_entry, head;

  assign redirect_tgt = {redirect_pc[ARCH_WIDTH-1:2], 2'b00};

  // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
  assign credit_ok     = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
  assign mem_req_valid = rst_n && !redirect_valid && credit_ok && (drop == '0);
  assign mem_req_addr  = fetch_pc;

  assign inst_valid = (count != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.instr;

  // Handshakes and next-state for PCs and counters; redirect overrides all.
  always_comb begin
    req_fire      = mem_req_valid && mem_req_ready;
    resp_fire     = mem_resp_valid && (outstanding != '0);
    drop_resp     = resp_fire && (drop != '0);
    push          = resp_fire && (drop == '0) && !redirect_valid;
    pop           = inst_valid && inst_ready;
    push_entry    = '{pc: resp_pc, instr: mem_resp_data};
    outstanding_d = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
    drop_d        = drop - CNT_W'(drop_resp);
    fetch_pc_d    = req_fire ? fetch_pc + ARCH_WIDTH'(PC_STEP) : fetch_pc;
    resp_pc_d     = push ? resp_pc + ARCH_WIDTH'(PC_STEP) : resp_pc;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_d     = outstanding - CNT_W'(resp_fire);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      fetch_pc    <= fetch_pc_d;
      resp_pc     <= resp_pc_d;
      outstanding <= outstanding_d;
      drop        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a 1-cycle in-order memory model.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  logic        resp_en;
  logic [63:0] pend[$];

  logic        o_req_v;
  logic [63:0] o_req_a;
  logic        o_iv;
  logic [63:0] o_pc;
  logic [31:0] o_data;

  typedef struct {
    logic        rdy;
    logic        req_v;
    logic [63:0] req_a;
    logic        iv;
    logic [63:0] pc;
  } vec_t;

  vec_t vecs[13];

  fetch_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return w ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs sampled, handshakes logged.
  task automatic tick();
    logic        hs_req, hs_resp;
    logic [63:0] a;
    if (resp_en && pend.size() != 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mdata(pend[0]);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    #1;
    o_req_v = mem_req_valid;
    o_req_a = mem_req_addr;
    o_iv    = inst_valid;
    o_pc    = inst_pc;
    o_data  = inst_data;
    hs_req  = mem_req_valid && mem_req_ready;
    hs_resp = mem_resp_valid;
    a       = mem_req_addr;
    @(posedge clk);
    if (hs_resp) void'(pend.pop_front());
    if (hs_req) pend.push_back(a);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b1;
    resp_en        = 1'b1;
    pend.delete();
    #1;
    chk("rst.req_valid", mem_req_valid, 0);
    chk("rst.req_addr", mem_req_addr, 0);
    chk("rst.inst_valid", inst_valid, 0);
    chk("rst.inst_pc", inst_pc, 0);
    chk("rst.inst_data", inst_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Backpressure: ready low fills exactly DEPTH, then drain and resume at 16.
    vecs[0]  = '{1'b0, 1'b1, 64'd0,  1'b0, 64'd0};
    vecs[1]  = '{1'b0, 1'b1, 64'd4,  1'b0, 64'd0};
    vecs[2]  = '{1'b0, 1'b1, 64'd8,  1'b1, 64'd0};
    vecs[3]  = '{1'b0, 1'b1, 64'd12, 1'b1, 64'd0};
    vecs[4]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    vecs[5]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    vecs[6]  = '{1'b0, 1'b0, 64'd16, 1'b1, 64'd0};
    vecs[7]  = '{1'b1, 1'b0, 64'd16, 1'b1, 64'd0};
    vecs[8]  = '{1'b1, 1'b1, 64'd16, 1'b1, 64'd4};
    vecs[9]  = '{1'b1, 1'b1, 64'd20, 1'b1, 64'd8};
    vecs[10] = '{1'b1, 1'b1, 64'd24, 1'b1, 64'd12};
    vecs[11] = '{1'b1, 1'b1, 64'd28, 1'b1, 64'd16};
    vecs[12] = '{1'b1, 1'b1, 64'd32, 1'b1, 64'd20};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      inst_ready = vecs[i].rdy;
      tick();
      chk($sformatf("tbl[%0d].req_valid", i), o_req_v, vecs[i].req_v);
      chk($sformatf("tbl[%0d].req_addr", i), o_req_a, vecs[i].req_a);
      chk($sformatf("tbl[%0d].inst_valid", i), o_iv, vecs[i].iv);
      if (vecs[i].iv) begin
        chk($sformatf("tbl[%0d].inst_pc", i), o_pc, vecs[i].pc);
        chk($sformatf("tbl[%0d].inst_data", i), o_data, mdata(vecs[i].pc));
      end
    end

    // Mid-operation reset, then streaming at one instruction per cycle.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 2) begin
        logic [63:0] epc;
        epc = 64'(4 * (c - 2));
        chk($sformatf("stream[%0d].inst_valid", c), o_iv, 1);
        chk($sformatf("stream[%0d].inst_pc", c), o_pc, epc);
        chk($sformatf("stream[%0d].inst_data", c), o_data, mdata(epc));
      end
    end

    // Memory not ready for 3 cycles: address holds, no duplicate entry.
    do_reset();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall[%0d].req_valid", c), o_req_v, 1);
      chk($sformatf("stall[%0d].req_addr", c), o_req_a, 0);
    end
    mem_req_ready = 1'b1;
    tick();
    chk("stall.fire_addr", o_req_a, 0);
    tick();
    chk("stall.c4_inst_valid", o_iv, 0);
    tick();
    chk("stall.first_pc", o_pc, 0);
    tick();
    chk("stall.second_pc", o_pc, 4);

    // Redirect with two requests in flight: both stale responses dropped.
    do_reset();
    resp_en = 1'b0;
    tick();
    chk("redir.req0", o_req_a, 0);
    tick();
    chk("redir.req1", o_req_a, 4);
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h107;
    tick();
    chk("redir.no_req_same_cycle", o_req_v, 0);
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    resp_en        = 1'b1;
    tick();
    chk("redir.drop1_req_valid", o_req_v, 0);
    chk("redir.drop1_inst_valid", o_iv, 0);
    tick();
    chk("redir.drop2_req_valid", o_req_v, 0);
    chk("redir.drop2_inst_valid", o_iv, 0);
    tick();
    chk("redir.new_req_valid", o_req_v, 1);
    chk("redir.new_req_addr", o_req_a, 64'h104);
    tick();
    chk("redir.fill_inst_valid", o_iv, 0);
    tick();
    chk("redir.first_pc", o_pc, 64'h104);
    chk("redir.first_data", o_data, mdata(64'h104));
    tick();
    chk("redir.second_pc", o_pc, 64'h108);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    chk("coinc.pop_valid", o_iv, 1);
    chk("coinc.pop_pc", o_pc, 0);
    chk("coinc.no_req", o_req_v, 0);
    redirect_valid = 1'b0;
    tick();
    chk("coinc.after_inst_valid", o_iv, 0);
    chk("coinc.req_valid", o_req_v, 1);
    chk("coinc.req_addr", o_req_a, 64'h200);
    tick();
    chk("coinc.fill_inst_valid", o_iv, 0);
    tick();
    chk("coinc.first_pc", o_pc, 64'h200);
    chk("coinc.first_data", o_data, mdata(64'h200));
    tick();
    chk("coinc.second_pc", o_pc, 64'h204);

    // Fetch address wraps from 2^64-4 to 0.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    chk("wrap.no_req", o_req_v, 0);
    redirect_valid = 1'b0;
    tick();
    chk("wrap.top_addr", o_req_a, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap.req_valid", o_req_v, 1);
    chk("wrap.zero_addr", o_req_a, 0);
    tick();
    chk("wrap.top_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.top_data", o_data, mdata(64'hFFFF_FFFF_FFFF_FFFC));
    tick();
    chk("wrap.zero_pc", o_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
